// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_pkg : mode and bounce-direction encodings for the LED sequencer        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/led_pattern_sequencer_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tick_gen : step prescaler; period latched only at tick, clamped to >= 1    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tick_gen #(
  parameter int TICK_DIV = 12_500_000,
  parameter int DIVW     = 26
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam logic [DIVW-1:0] C_TICK_DIV = DIVW'(TICK_DIV);

  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] div;
  logic [DIVW-1:0] div_next;

  // Fast speeds can shift a small base period down to zero; never go below one cycle.
  always_comb begin
    div_next = C_TICK_DIV >> speed;
    if (div_next == '0) div_next = DIVW'(1);
  end

  // Combinational strobe: the top registers it so LEDG and the tick pulse share an edge.
  assign tick = (cnt == div - DIVW'(1));

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      cnt <= '0;
      div <= C_TICK_DIV;
    end else if (tick) begin
      cnt <= '0;
      div <= div_next;
    end else begin
      cnt <= cnt + DIVW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_pattern_sequencer : switch-selected LED patterns stepped by a tick     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int N_LEDS   = 8,
  parameter int TICK_DIV = 12_500_000,
  parameter int DIVW     = 26
) (
  input  logic              CLOCK_50,
  input  logic [0:0]        KEY,
  input  logic [3:0]        SW,
  output logic [N_LEDS-1:0] LEDG,
  output logic              tick,
  output logic [1:0]        mode
);

  localparam logic [N_LEDS-1:0] C_LED_BIT0 = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] C_LED_MSB  = {1'b1, {(N_LEDS-1){1'b0}}};

  logic              rst;
  logic [3:0]        sw_q;
  logic              step;
  mode_e             mode_q, mode_d, mode_req;
  dir_e              dir_q, dir_d;
  logic [N_LEDS-1:0] led_q, led_d;

  assign rst      = KEY[0];
  assign mode_req = mode_e'(sw_q[1:0]);

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .DIVW     (DIVW)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .speed    (sw_q[3:2]),
    .tick     (step)
  );

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    led_d  = led_q;
    if (step) begin
      if (mode_req != mode_q) begin
        // A mode switch only loads the new pattern's start; stepping resumes next tick.
        mode_d = mode_req;
        dir_d  = DIR_LEFT;
        case (mode_req)
          MODE_OFF:   led_d = '0;
          MODE_BLINK: led_d = '1;
          default:    led_d = C_LED_BIT0;
        endcase
      end else begin
        case (mode_q)
          MODE_OFF:   led_d = '0;
          MODE_BLINK: led_d = ~led_q;
          MODE_CHASE: led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
          default: begin
            // Direction flips on the step that lands on an end, so ends are not repeated.
            if (dir_q == DIR_LEFT) begin
              led_d = led_q << 1;
              if (led_d == C_LED_MSB) dir_d = DIR_RIGHT;
            end else begin
              led_d = led_q >> 1;
              if (led_d == C_LED_BIT0) dir_d = DIR_LEFT;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sw_q   <= '0;
      tick   <= 1'b0;
      mode_q <= MODE_OFF;
      dir_q  <= DIR_LEFT;
      led_q  <= '0;
    end else begin
      sw_q   <= SW;
      tick   <= step;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
    end
  end

  assign LEDG = led_q;
  assign mode = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_pattern_sequencer : directed bench, TICK_DIV=4, N_LEDS=4            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_led_pattern_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic [0:0] KEY      = 1'b1;
  logic [3:0] SW       = 4'b0000;
  logic [3:0] LEDG;
  logic       tick;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  led_pattern_sequencer #(
    .N_LEDS   (4),
    .TICK_DIV (4),
    .DIVW     (26)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .LEDG     (LEDG),
    .tick     (tick),
    .mode     (mode)
  );

  // Returns the number of falling edges until tick is seen high.
  task automatic wait_tick(output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLOCK_50);
      n++;
      if (tick === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      $display("FAIL tick_timeout: no tick after %0d cycles, required within 40", n);
      n_bad++;
    end
  endtask

  task automatic do_reset(input logic [3:0] sw);
    @(negedge CLOCK_50);
    KEY = 1'b1;
    SW  = sw;
    repeat (3) @(negedge CLOCK_50);
    KEY = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    @(negedge CLOCK_50);
    KEY = 1'b1;
    SW  = 4'b0001;
    repeat (3) @(negedge CLOCK_50);
    n_cmp++; if (LEDG !== 4'b0000) begin $display("FAIL reset_ledg: got %b want 0000", LEDG); n_bad++; end
    n_cmp++; if (tick !== 1'b0)    begin $display("FAIL reset_tick: got %b want 0", tick); n_bad++; end
    n_cmp++; if (mode !== 2'b00)   begin $display("FAIL reset_mode: got %b want 00", mode); n_bad++; end
    KEY = 1'b0;
    wait_tick(n);
    n_cmp++; if (n !== 4)          begin $display("FAIL reset_first_tick: got %0d want 4", n); n_bad++; end
    n_cmp++; if (LEDG !== 4'b1111) begin $display("FAIL blink_init: got %b want 1111", LEDG); n_bad++; end
    n_cmp++; if (mode !== 2'b01)   begin $display("FAIL blink_mode: got %b want 01", mode); n_bad++; end
    wait_tick(n);
    n_cmp++; if (n !== 4)          begin $display("FAIL blink_period: got %0d want 4", n); n_bad++; end
    n_cmp++; if (LEDG !== 4'b0000) begin $display("FAIL blink_step: got %b want 0000", LEDG); n_bad++; end
  endtask

  task automatic test_chase;
    logic [3:0] exp_led [5];
    int n;
    exp_led = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset(4'b0010);
    for (int i = 0; i < 5; i++) begin
      wait_tick(n);
      n_cmp++; if (n !== 4) begin $display("FAIL chase_period[%0d]: got %0d want 4", i, n); n_bad++; end
      n_cmp++; if (LEDG !== exp_led[i]) begin $display("FAIL chase_led[%0d]: got %b want %b", i, LEDG, exp_led[i]); n_bad++; end
    end
  endtask

  task automatic test_bounce;
    logic [3:0] exp_led [8];
    int n;
    exp_led = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    do_reset(4'b0011);
    for (int i = 0; i < 8; i++) begin
      wait_tick(n);
      n_cmp++; if (LEDG !== exp_led[i]) begin $display("FAIL bounce_led[%0d]: got %b want %b", i, LEDG, exp_led[i]); n_bad++; end
    end
  endtask

  task automatic test_speed;
    int exp_n [6];
    int n;
    exp_n = '{4, 2, 2, 2, 1, 1};
    do_reset(4'b0100);
    for (int i = 0; i < 6; i++) begin
      wait_tick(n);
      n_cmp++; if (n !== exp_n[i]) begin $display("FAIL speed_period[%0d]: got %0d want %0d", i, n, exp_n[i]); n_bad++; end
      // Request 4x one cycle after the third tick; the current 2-cycle period must finish.
      if (i == 2) SW = 4'b1000;
    end
    SW = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      n_cmp++; if (n !== 1) begin $display("FAIL speed_clamp[%0d]: got %0d want 1", i, n); n_bad++; end
    end
  endtask

  task automatic test_mode_change;
    int n;
    do_reset(4'b0010);
    repeat (3) wait_tick(n);
    n_cmp++; if (LEDG !== 4'b0100) begin $display("FAIL modechg_pre: got %b want 0100", LEDG); n_bad++; end
    SW = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLOCK_50);
      n_cmp++; if (LEDG !== 4'b0100) begin $display("FAIL modechg_hold[%0d]: got %b want 0100", i, LEDG); n_bad++; end
      n_cmp++; if (mode !== 2'b10)   begin $display("FAIL modechg_mode_hold[%0d]: got %b want 10", i, mode); n_bad++; end
    end
    wait_tick(n);
    n_cmp++; if (n !== 2)          begin $display("FAIL modechg_remaining: got %0d want 2", n); n_bad++; end
    n_cmp++; if (LEDG !== 4'b0000) begin $display("FAIL modechg_led: got %b want 0000", LEDG); n_bad++; end
    n_cmp++; if (mode !== 2'b00)   begin $display("FAIL modechg_mode: got %b want 00", mode); n_bad++; end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset(4'b0011);
    repeat (5) wait_tick(n);
    n_cmp++; if (LEDG !== 4'b0100) begin $display("FAIL midrst_pre: got %b want 0100", LEDG); n_bad++; end
    KEY = 1'b1;
    @(negedge CLOCK_50);
    n_cmp++; if (LEDG !== 4'b0000) begin $display("FAIL midrst_led: got %b want 0000", LEDG); n_bad++; end
    n_cmp++; if (mode !== 2'b00)   begin $display("FAIL midrst_mode: got %b want 00", mode); n_bad++; end
    n_cmp++; if (tick !== 1'b0)    begin $display("FAIL midrst_tick: got %b want 0", tick); n_bad++; end
    KEY = 1'b0;
    wait_tick(n);
    n_cmp++; if (n !== 4)          begin $display("FAIL midrst_first_tick: got %0d want 4", n); n_bad++; end
    n_cmp++; if (LEDG !== 4'b0001) begin $display("FAIL midrst_init: got %b want 0001", LEDG); n_bad++; end
    wait_tick(n);
    n_cmp++; if (LEDG !== 4'b0010) begin $display("FAIL midrst_dir_left: got %b want 0010", LEDG); n_bad++; end
  endtask

  task automatic test_back_to_back;
    int n;
    do_reset(4'b0000);
    wait_tick(n);
    n_cmp++; if (LEDG !== 4'b0000) begin $display("FAIL b2b_off: got %b want 0000", LEDG); n_bad++; end
    SW = 4'b0101;
    wait_tick(n);
    n_cmp++; if (n !== 4)          begin $display("FAIL b2b_old_period: got %0d want 4", n); n_bad++; end
    n_cmp++; if (LEDG !== 4'b1111) begin $display("FAIL b2b_blink_init: got %b want 1111", LEDG); n_bad++; end
    wait_tick(n);
    n_cmp++; if (n !== 2)          begin $display("FAIL b2b_new_period: got %0d want 2", n); n_bad++; end
    n_cmp++; if (LEDG !== 4'b0000) begin $display("FAIL b2b_blink_step: got %b want 0000", LEDG); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_chase();
    test_bounce();
    test_speed();
    test_mode_change();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
